m_window_3x3: RTL and testbench
===============================

// Module: m_window_3x3
// PURPOSE
//  3x3 sliding-window generator for the first convolution layer. Sits directly
//  downstream of the layer-0 input stage and shares its pixel stream
//  (start + d_in, one pixel per clk, raster order, 28x28 frame).
//  Buffers two image rows and emits one registered 3x3 window per valid
//  position (26x26 = 676 windows per frame) to the convolution MAC stage.
// PARAMETERS
//  IMG_W    28  pixels per row (line-buffer depth)
//  IMG_H    28  rows per frame
//  DATA_W   8   pixel width; kernel size is fixed at 3
// PORTS
//  clk         in   1           system clock, rising edge
//  rst         in   1           asynchronous reset, active-low
//  start       in   1           frame enable; each high cycle accepts one pixel
//  d_in        in   DATA_W      pixel, sampled when start=1 and frame not full
//  win_out     out  9*DATA_W    {w00,w01,w02,w10,w11,w12,w20,w21,w22}; w00 at MSB
//  win_valid   out  1           win_out holds a complete window this cycle
//  win_last    out  1           with win_valid: final window of frame (676th)
//  frame_done  out  1           1-cycle pulse after the 784th pixel is accepted
// BEHAVIOUR
//  - Reset (rst=0, async): all outputs 0, col/row/pixel counters 0. Line-buffer
//    contents are don't-care; no window is emitted from stale data.
//  - Accept: pixel accepted iff start=1 and pix_cnt < IMG_W*IMG_H.
//    col 0..IMG_W-1 wraps to 0 and increments row; pix_cnt saturates at 784.
//  - start=0 in any cycle: counters clear to 0 next edge; win_valid/win_last 0.
//    Partial frame is abandoned; next start=1 begins a new frame at (0,0).
//  - start held high after 784 pixels: d_in ignored, no windows, no new
//    frame_done until start drops.
//  - Line buffers: two IMG_W-deep delay lines; lb0 output = pixel one row
//    above d_in, lb1 output = two rows above. Shift only on accept.
//  - Window regs: on accept, each window row shifts left one column; new
//    right column = {lb1_out, lb0_out, d_in} -> {w02, w12, w22}.
//  - Output: for accepted pixel (r,c) with r>=2 and c>=2, next cycle
//    win_valid=1, w22=(r,c), w00=(r-2,c-2). Latency 1 clk. Columns c=0,1
//    never emit (no window straddles a row boundary). 26 windows per row.
//  - win_last=1 with the window whose w22=(27,27); frame_done pulses same
//    cycle. Both 0 otherwise.
//  - win_valid is a pulse per accepted pixel; no back-pressure (consumer must
//    take every window).
//  - Counter widths: col/row 5 bits, pix_cnt 10 bits; comparisons unsigned.
// STRUCTURE
//  - m_conv_pkg: IMG_W, IMG_H, DATA_W, KERNEL=3, IMG_PIX=784, WIN_PER_FRAME=676.
//  - Sub-module m_line_fifo (shift-enable delay line, depth IMG_W, width
//    DATA_W), instantiated twice. Top holds counters, window regs, flags.
// TESTING
//  1. Reset then start=1 for 784 clk, d_in=idx mod 256 -> first win_valid one
//     clk after idx 58 with window {0,1,2,28,29,30,56,57,58}; 676 valids total.
//  2. Same run -> last window {213,214,215,241,242,243,13,14,15}, win_last=1
//     and frame_done=1 same cycle; exactly 26 valids per row, none at c=0,1.
//  3. start=0 for 1 clk at idx 100, then full frame -> no valid during the gap,
//     first valid again after new frame's 59th pixel, 676 valids.
//  4. start held 850 clk -> no win_valid after win_last, frame_done once only.
//  5. rst=0 mid-frame (idx 300, async, between edges) -> all outputs 0
//     immediately; after release a fresh frame produces window 1 as in test 1.
//  6. Two frames separated by one start=0 clk, frame 2 d_in=255-idx ->
//     frame-2 first window {255,254,253,227,226,225,199,198,197}.

Source files
------------

// File: rtl/m_conv_pkg.sv
// Shared constants and types for the layer-0 convolution front end.
// Frame geometry and counter widths live here so every stage agrees on them.
package m_conv_pkg;

  localparam int IMG_W         = 28;
  localparam int IMG_H         = 28;
  localparam int DATA_W        = 8;
  localparam int KERNEL        = 3;
  localparam int IMG_PIX       = IMG_W * IMG_H;
  localparam int WIN_PER_FRAME = (IMG_W - KERNEL + 1) * (IMG_H - KERNEL + 1);

  localparam int COL_W = 5;
  localparam int ROW_W = 5;
  localparam int CNT_W = 10;

  typedef logic [DATA_W-1:0]             pix_t;
  // One window row; element [KERNEL-1] is the leftmost (oldest) column.
  typedef logic [KERNEL-1:0][DATA_W-1:0] win_row_t;

  // A window is complete once two full rows and two columns precede the pixel.
  function automatic logic win_pos_ok(input logic [ROW_W-1:0] row,
                                      input logic [COL_W-1:0] col);
    return (row >= ROW_W'(KERNEL - 1)) && (col >= COL_W'(KERNEL - 1));
  endfunction

  function automatic logic last_pos(input logic [ROW_W-1:0] row,
                                    input logic [COL_W-1:0] col);
    return (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));
  endfunction

endpackage

// File: rtl/m_line_fifo.sv
// Shift-enable delay line: d_out is the sample written DEPTH enables ago.
// Contents are never reset; the window logic masks them until refilled.
module m_line_fifo #(
  parameter int DEPTH = 28,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (shift_en) begin
      mem_q[0] <= d_in;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign d_out = mem_q[DEPTH-1];

endmodule

// File: rtl/m_window_3x3.sv
// 3x3 sliding-window generator: two row buffers plus a 3x3 register array,
// emitting one registered window per interior pixel of a raster-order frame.
module m_window_3x3
  import m_conv_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DATA_W-1:0]        d_in,
  output logic [KERNEL*KERNEL*DATA_W-1:0] win_out,
  output logic                     win_valid,
  output logic                     win_last,
  output logic                     frame_done
);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic             accept;

  win_row_t win_q [KERNEL];
  win_row_t win_d [KERNEL];

  logic valid_q, valid_d;
  logic last_q, last_d;
  logic done_q, done_d;

  pix_t lb0_out, lb1_out;

  assign accept = start && (pix_cnt_q < CNT_W'(IMG_PIX));

  m_line_fifo #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb0 (
    .clk      (clk),
    .shift_en (accept),
    .d_in     (d_in),
    .d_out    (lb0_out)
  );

  m_line_fifo #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb1 (
    .clk      (clk),
    .shift_en (accept),
    .d_in     (lb0_out),
    .d_out    (lb1_out)
  );

  // Dropping start abandons the frame; the next accepted pixel is (0,0).
  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    pix_cnt_d = pix_cnt_q;
    if (!start) begin
      col_d     = '0;
      row_d     = '0;
      pix_cnt_d = '0;
    end else if (accept) begin
      pix_cnt_d = pix_cnt_q + 1'b1;
      if (col_q == COL_W'(IMG_W - 1)) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < KERNEL; k++) begin
      win_d[k] = win_q[k];
    end
    if (accept) begin
      win_d[0] = {win_q[0][KERNEL-2:0], lb1_out};
      win_d[1] = {win_q[1][KERNEL-2:0], lb0_out};
      win_d[2] = {win_q[2][KERNEL-2:0], d_in};
    end
  end

  always_comb begin
    valid_d = accept && win_pos_ok(row_q, col_q);
    last_d  = accept && last_pos(row_q, col_q);
    done_d  = last_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q     <= '0;
      row_q     <= '0;
      pix_cnt_q <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int k = 0; k < KERNEL; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      pix_cnt_q <= pix_cnt_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      done_q    <= done_d;
      for (int k = 0; k < KERNEL; k++) begin
        win_q[k] <= win_d[k];
      end
    end
  end

  assign win_out    = {win_q[0], win_q[1], win_q[2]};
  assign win_valid  = valid_q;
  assign win_last   = last_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_m_window_3x3.sv
// Bench for m_window_3x3: an image-array reference model checked every cycle,
// directed frame scenarios with literal windows, and a randomized start/d_in run.
module tb_m_window_3x3;
  import m_conv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  d_in = 8'd0;
  logic [71:0] win_out;
  logic        win_valid, win_last, frame_done;

  int total = 0;
  int bad   = 0;

  m_window_3x3 dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .d_in       (d_in),
    .win_out    (win_out),
    .win_valid  (win_valid),
    .win_last   (win_last),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: pixel n of the frame lands at (n/28, n%28); a window is
  // the 3x3 block of the image ending at that pixel.
  logic [7:0]  img [28][28];
  int          m_n;
  logic        exp_valid, exp_last, exp_done;
  logic [71:0] exp_win;

  function automatic logic [71:0] win_at(input int r, input int c, input logic [7:0] cur);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (i == 2 && j == 2) w[7:0] = cur;
        else w[71 - 8*(3*i + j) -: 8] = img[r - 2 + i][c - 2 + j];
      end
    end
    return w;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_n       <= 0;
      exp_valid <= 1'b0;
      exp_last  <= 1'b0;
      exp_done  <= 1'b0;
      exp_win   <= '0;
    end else if (!start) begin
      m_n       <= 0;
      exp_valid <= 1'b0;
      exp_last  <= 1'b0;
      exp_done  <= 1'b0;
    end else if (m_n < 784) begin
      img[m_n / 28][m_n % 28] <= d_in;
      m_n       <= m_n + 1;
      exp_valid <= (m_n / 28 >= 2) && (m_n % 28 >= 2);
      exp_last  <= (m_n == 783);
      exp_done  <= (m_n == 783);
      if ((m_n / 28 >= 2) && (m_n % 28 >= 2)) exp_win <= win_at(m_n / 28, m_n % 28, d_in);
    end else begin
      exp_valid <= 1'b0;
      exp_last  <= 1'b0;
      exp_done  <= 1'b0;
    end
  end

  int          cyc, valid_cnt, first_cyc, last_cnt, done_cnt, after_last;
  logic [71:0] first_win, last_win;

  always @(negedge clk) begin
    cyc++;
    chk("win_valid", win_valid, exp_valid);
    chk("win_last", win_last, exp_last);
    chk("frame_done", frame_done, exp_done);
    if (exp_valid || !rst) chk("win_out", win_out, exp_win);
    if (win_valid) begin
      if (valid_cnt == 0) begin
        first_win = win_out;
        first_cyc = cyc;
      end
      valid_cnt++;
      if (last_cnt > 0) after_last++;
    end
    if (win_last) begin
      last_win = win_out;
      last_cnt++;
    end
    if (frame_done) done_cnt++;
  end

  task automatic clear_stats;
    cyc = 0; valid_cnt = 0; first_cyc = 0; last_cnt = 0; done_cnt = 0; after_last = 0;
    first_win = '0; last_win = '0;
  endtask

  task automatic drive(input logic s, input logic [7:0] d);
    @(negedge clk);
    #1;
    start = s;
    d_in  = d;
  endtask

  task automatic frame(input bit inv);
    for (int i = 0; i < 784; i++) drive(1'b1, inv ? 8'(255 - i) : 8'(i));
  endtask

  localparam logic [71:0] WIN_FIRST = {8'd0, 8'd1, 8'd2, 8'd28, 8'd29, 8'd30, 8'd56, 8'd57, 8'd58};
  localparam logic [71:0] WIN_LAST  = {8'd213, 8'd214, 8'd215, 8'd241, 8'd242, 8'd243, 8'd13, 8'd14, 8'd15};
  localparam logic [71:0] WIN_INV   = {8'd255, 8'd254, 8'd253, 8'd227, 8'd226, 8'd225, 8'd199, 8'd198, 8'd197};

  initial begin
    clear_stats();
    repeat (3) drive(1'b0, 8'd0);
    chk("reset_win_out", win_out, 72'd0);
    chk("reset_valid", win_valid, 1'b0);
    rst = 1'b1;

    // Full frame, idx pattern.
    clear_stats();
    frame(1'b0);
    drive(1'b0, 8'd0);
    chk("t1_first_win", first_win, WIN_FIRST);
    chk("t1_first_cyc", first_cyc, 60);
    chk("t1_valid_cnt", valid_cnt, 676);
    chk("t2_last_win", last_win, WIN_LAST);
    chk("t2_last_cnt", last_cnt, 1);
    chk("t2_done_cnt", done_cnt, 1);

    // One-cycle start drop at idx 100, then a fresh frame.
    for (int i = 0; i < 100; i++) drive(1'b1, 8'(i));
    drive(1'b0, 8'd0);
    clear_stats();
    frame(1'b0);
    drive(1'b0, 8'd0);
    chk("t3_first_win", first_win, WIN_FIRST);
    chk("t3_first_cyc", first_cyc, 60);
    chk("t3_valid_cnt", valid_cnt, 676);

    // start held past the end of the frame.
    clear_stats();
    for (int i = 0; i < 850; i++) drive(1'b1, 8'(i));
    drive(1'b0, 8'd0);
    chk("t4_valid_cnt", valid_cnt, 676);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_after_last", after_last, 0);

    // Async reset mid-frame, between clock edges.
    for (int i = 0; i <= 300; i++) drive(1'b1, 8'(i));
    @(posedge clk);
    #3;
    chk("t5_pre_valid", win_valid, 1'b1);
    rst = 1'b0;
    #1;
    chk("t5_rst_win_out", win_out, 72'd0);
    chk("t5_rst_valid", win_valid, 1'b0);
    chk("t5_rst_last", win_last, 1'b0);
    chk("t5_rst_done", frame_done, 1'b0);
    repeat (3) drive(1'b0, 8'd0);
    rst = 1'b1;
    clear_stats();
    frame(1'b0);
    drive(1'b0, 8'd0);
    chk("t5_first_win", first_win, WIN_FIRST);
    chk("t5_first_cyc", first_cyc, 60);
    chk("t5_valid_cnt", valid_cnt, 676);

    // Back-to-back frames, second one inverted.
    frame(1'b0);
    drive(1'b0, 8'd0);
    clear_stats();
    frame(1'b1);
    drive(1'b0, 8'd0);
    chk("t6_first_win", first_win, WIN_INV);
    chk("t6_first_cyc", first_cyc, 60);
    chk("t6_valid_cnt", valid_cnt, 676);

    // Random pixels with occasional start drops, checked by the model.
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(0, 299) != 0), 8'($urandom));
    end
    drive(1'b0, 8'd0);
    drive(1'b0, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
